// File: rtl/command_entry_pkg.sv
// Shared constants, digit-position codes and FSM states for the command entry path.
// The command word is {address[4:0], command[6:0]}, edited one hex digit at a time.
package command_entry_pkg;

  localparam int ADDR_W = 5;
  localparam int CMD_W  = 7;
  localparam int WORD_W = ADDR_W + CMD_W;

  typedef enum logic [1:0] {
    POS_ADDR_MSB = 2'd0,
    POS_ADDR_LO  = 2'd1,
    POS_CMD_HI   = 2'd2,
    POS_CMD_LO   = 2'd3
  } digit_pos_t;

  typedef enum logic {
    ST_EDIT    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Digits follow display order; each is truncated to the width of its field.
  function automatic logic [WORD_W-1:0] insert_digit(
    input logic [WORD_W-1:0] word,
    input digit_pos_t        pos,
    input logic [3:0]        digit
  );
    logic [WORD_W-1:0] result;
    result = word;
    case (pos)
      POS_ADDR_MSB: result[WORD_W-1]       = digit[0];
      POS_ADDR_LO:  result[WORD_W-2 -: 4]  = digit;
      POS_CMD_HI:   result[CMD_W-1 -: 3]   = digit[2:0];
      POS_CMD_LO:   result[3:0]            = digit;
      default:      result                 = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/command_entry_button_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge detector for one raw button.
// A button held through reset must be released once before it can produce a press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync;
  logic [1:0]       fill;
  logic             armed;
  logic             level_q;
  logic [CNT_W-1:0] count;

  // The level flips once the counter has seen DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '0;
      fill    <= '0;
      armed   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      count   <= '0;
    end else begin
      sync    <= {sync[0], raw};
      fill    <= {fill[0], 1'b1};
      level_q <= level;
      if (fill[1] && !sync[1]) begin
        armed <= 1'b1;
      end
      if (count == CNT_MAX) begin
        level <= ~level;
        count <= '0;
      end else if (sync[1] != level) begin
        count <= count + CNT_W'(1);
      end else begin
        count <= '0;
      end
    end
  end

  assign press = level & ~level_q & armed;

endmodule

// File: rtl/command_entry.sv
// Builds the 12-bit command word from switch digits and debounced buttons,
// then offers it to the consumer through a valid/ready handshake.
module command_entry
  import command_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        digit_in,
  input  logic              btn_next_raw,
  input  logic              btn_enter_raw,
  input  logic              btn_clear_raw,
  input  logic              cmd_ready,
  output logic [WORD_W-1:0] cmd_buf,
  output logic              cmd_valid,
  output logic [1:0]        cursor
);

  logic [2:0] unused_levels;
  logic       next_ev;
  logic       enter_ev;
  logic       clear_ev;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next_raw),
    .level (unused_levels[0]),
    .press (next_ev)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_enter_raw),
    .level (unused_levels[1]),
    .press (enter_ev)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_clear_raw),
    .level (unused_levels[2]),
    .press (clear_ev)
  );

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] buf_next;
  logic [1:0]        cursor_next;
  logic              valid_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EDIT;
      cmd_buf   <= '0;
      cursor    <= 2'd0;
      cmd_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_buf   <= buf_next;
      cursor    <= cursor_next;
      cmd_valid <= valid_next;
    end
  end

  // Only the strongest event in a cycle acts (clear, then enter, then next);
  // while a command is pending every button event is discarded.
  always_comb begin
    state_next  = state;
    buf_next    = cmd_buf;
    cursor_next = cursor;
    valid_next  = cmd_valid;
    case (state)
      ST_EDIT: begin
        if (clear_ev) begin
          buf_next    = '0;
          cursor_next = 2'd0;
        end else if (enter_ev) begin
          valid_next = 1'b1;
          state_next = ST_PENDING;
        end else if (next_ev) begin
          buf_next    = insert_digit(cmd_buf, digit_pos_t'(cursor), digit_in);
          cursor_next = cursor + 2'd1;
        end
      end
      ST_PENDING: begin
        if (cmd_valid && cmd_ready) begin
          valid_next  = 1'b0;
          cursor_next = 2'd0;
          state_next  = ST_EDIT;
        end
      end
      default: begin
        state_next = ST_EDIT;
      end
    endcase
  end

endmodule

// File: tb/tb_command_entry.sv
// Self-checking bench for command_entry: a vector table, hand-written timing corners,
// and randomized button traffic compared with an event-level reference model.
module tb_command_entry;

  localparam int OP_NEXT  = 0;
  localparam int OP_CLEAR = 1;
  localparam int OP_ENTER = 2;
  localparam int OP_READY = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_in;
  logic        btn_next_raw;
  logic        btn_enter_raw;
  logic        btn_clear_raw;
  logic        cmd_ready;
  logic [11:0] cmd_buf;
  logic        cmd_valid;
  logic [1:0]  cursor;

  int errors = 0;
  int checks = 0;

  logic [11:0] m_buf;
  logic [1:0]  m_cur;
  logic        m_valid;

  logic watch = 1'b0;
  int   low_seen = 0;

  typedef struct {
    int          op;
    logic [3:0]  digit;
    logic [11:0] exp_buf;
    logic [1:0]  exp_cur;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[13];

  command_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .digit_in      (digit_in),
    .btn_next_raw  (btn_next_raw),
    .btn_enter_raw (btn_enter_raw),
    .btn_clear_raw (btn_clear_raw),
    .cmd_ready     (cmd_ready),
    .cmd_buf       (cmd_buf),
    .cmd_valid     (cmd_valid),
    .cursor        (cursor)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (watch && cmd_valid !== 1'b1) low_seen++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Field layout as {lsb, width} per display position.
  function automatic logic [11:0] model_put(input logic [11:0] w, input int pos, input logic [3:0] d);
    int lsb[4] = '{11, 7, 4, 0};
    int wid[4] = '{1, 4, 3, 4};
    int mask;
    int v;
    mask = (1 << wid[pos]) - 1;
    v = int'(w);
    v = (v & ~(mask << lsb[pos])) | ((int'(d) & mask) << lsb[pos]);
    return v[11:0];
  endfunction

  task automatic model_event(input logic nx, input logic en, input logic cl, input logic [3:0] d);
    if (m_valid) return;
    if (cl) begin
      m_buf = 12'h000;
      m_cur = 2'd0;
    end else if (en) begin
      m_valid = 1'b1;
    end else if (nx) begin
      m_buf = model_put(m_buf, int'(m_cur), d);
      m_cur = 2'((int'(m_cur) + 1) % 4);
    end
  endtask

  task automatic model_reset();
    m_buf = 12'h000;
    m_cur = 2'd0;
    m_valid = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, ".cmd_buf"}, 32'(cmd_buf), 32'(m_buf));
    check_output({tag, ".cursor"}, 32'(cursor), 32'(m_cur));
    check_output({tag, ".cmd_valid"}, 32'(cmd_valid), 32'(m_valid));
  endtask

  // One clean press: hold 10 cycles, release 10 cycles; digit scrambled after release.
  task automatic apply_stimulus(input logic nx, input logic en, input logic cl, input logic [3:0] d);
    @(negedge clk);
    digit_in = d;
    btn_next_raw = nx;
    btn_enter_raw = en;
    btn_clear_raw = cl;
    repeat (10) @(negedge clk);
    btn_next_raw = 1'b0;
    btn_enter_raw = 1'b0;
    btn_clear_raw = 1'b0;
    digit_in = 4'($urandom);
    repeat (10) @(negedge clk);
    model_event(nx, en, cl, d);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_cur = 2'd0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input int op, input logic [3:0] d);
    case (op)
      OP_NEXT:  apply_stimulus(1'b1, 1'b0, 1'b0, d);
      OP_CLEAR: apply_stimulus(1'b0, 1'b0, 1'b1, d);
      OP_ENTER: apply_stimulus(1'b0, 1'b1, 1'b0, d);
      default:  pulse_ready();
    endcase
  endtask

  initial begin
    vecs[0]  = '{OP_NEXT,  4'h1, 12'h800, 2'd1, 1'b0};
    vecs[1]  = '{OP_NEXT,  4'hA, 12'hD00, 2'd2, 1'b0};
    vecs[2]  = '{OP_NEXT,  4'h5, 12'hD50, 2'd3, 1'b0};
    vecs[3]  = '{OP_NEXT,  4'h3, 12'hD53, 2'd0, 1'b0};
    vecs[4]  = '{OP_CLEAR, 4'h0, 12'h000, 2'd0, 1'b0};
    vecs[5]  = '{OP_NEXT,  4'hF, 12'h800, 2'd1, 1'b0};
    vecs[6]  = '{OP_NEXT,  4'h0, 12'h800, 2'd2, 1'b0};
    vecs[7]  = '{OP_NEXT,  4'hF, 12'h870, 2'd3, 1'b0};
    vecs[8]  = '{OP_ENTER, 4'h0, 12'h870, 2'd3, 1'b1};
    vecs[9]  = '{OP_NEXT,  4'h2, 12'h870, 2'd3, 1'b1};
    vecs[10] = '{OP_CLEAR, 4'h0, 12'h870, 2'd3, 1'b1};
    vecs[11] = '{OP_READY, 4'h0, 12'h870, 2'd0, 1'b0};
    vecs[12] = '{OP_NEXT,  4'h4, 12'h070, 2'd1, 1'b0};

    rst = 1'b1;
    digit_in = 4'h0;
    btn_next_raw = 1'b0;
    btn_enter_raw = 1'b0;
    btn_clear_raw = 1'b0;
    cmd_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_output("reset.cmd_buf", 32'(cmd_buf), 32'h0);
    check_output("reset.cursor", 32'(cursor), 32'h0);
    check_output("reset.cmd_valid", 32'(cmd_valid), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_model("post_reset");

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].digit);
      check_output($sformatf("vec%0d.cmd_buf", i), 32'(cmd_buf), 32'(vecs[i].exp_buf));
      check_output($sformatf("vec%0d.cursor", i), 32'(cursor), 32'(vecs[i].exp_cur));
      check_output($sformatf("vec%0d.cmd_valid", i), 32'(cmd_valid), 32'(vecs[i].exp_valid));
    end

    // Event latency: raw rises before edge 0, state updates on edge 2+4+1.
    @(negedge clk);
    digit_in = 4'h2;
    btn_next_raw = 1'b1;
    repeat (7) @(posedge clk);
    #1 check_output("latency.before", 32'(cursor), 32'd1);
    @(posedge clk);
    #1 check_output("latency.edge", 32'(cursor), 32'd2);
    repeat (8) @(negedge clk);
    btn_next_raw = 1'b0;
    repeat (10) @(negedge clk);
    model_event(1'b1, 1'b0, 1'b0, 4'h2);
    check_model("latency");

    // Bounce: 2-cycle toggling, 3-sample burst, then 4-sample burst and a stable press.
    for (int i = 0; i < 5; i++) begin
      btn_next_raw = 1'b1;
      repeat (2) @(negedge clk);
      btn_next_raw = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check_model("bounce.toggle");
    btn_next_raw = 1'b1;
    repeat (3) @(negedge clk);
    btn_next_raw = 1'b0;
    repeat (10) @(negedge clk);
    check_model("bounce.short3");
    digit_in = 4'h6;
    btn_next_raw = 1'b1;
    repeat (4) @(negedge clk);
    btn_next_raw = 1'b0;
    repeat (10) @(negedge clk);
    model_event(1'b1, 1'b0, 1'b0, 4'h6);
    check_model("bounce.exact4");
    for (int i = 0; i < 5; i++) begin
      btn_next_raw = 1'b1;
      repeat (2) @(negedge clk);
      btn_next_raw = 1'b0;
      repeat (2) @(negedge clk);
    end
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'h9);
    check_model("bounce.settled");

    // Handshake: held pending for 50 cycles with presses ignored, then one-cycle ready.
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'h0);
    check_model("hs.enter");
    low_seen = 0;
    watch = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'hE);
    apply_stimulus(1'b0, 1'b0, 1'b1, 4'h0);
    repeat (10) @(negedge clk);
    watch = 1'b0;
    check_output("hs.valid_held", 32'(low_seen), 32'd0);
    check_model("hs.frozen");
    check_output("hs.before_ready", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    m_cur = 2'd0;
    check_model("hs.accept");
    @(negedge clk);
    cmd_ready = 1'b0;

    // Simultaneous events.
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'h9);
    apply_stimulus(1'b0, 1'b1, 1'b1, 4'h0);
    check_output("sim.clear_enter.buf", 32'(cmd_buf), 32'h0);
    check_output("sim.clear_enter.valid", 32'(cmd_valid), 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'h5);
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'hA);
    check_output("sim.enter_next.buf", 32'(cmd_buf), 32'h800);
    check_output("sim.enter_next.valid", 32'(cmd_valid), 32'h1);
    check_model("sim.enter_next");

    // Asynchronous reset while pending.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("rst_pending.cmd_buf", 32'(cmd_buf), 32'h0);
    check_output("rst_pending.cmd_valid", 32'(cmd_valid), 32'h0);
    check_output("rst_pending.cursor", 32'(cursor), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-debounce with the button still held afterwards.
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'h1);
    check_model("rst_db.setup");
    digit_in = 4'h3;
    btn_next_raw = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("rst_db.cmd_buf", 32'(cmd_buf), 32'h0);
    check_output("rst_db.cursor", 32'(cursor), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
    check_model("rst_db.held");
    btn_next_raw = 1'b0;
    repeat (10) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'h7);
    check_model("rst_db.repress");

    // Randomized traffic against the event-level model.
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [2:0] m;
      logic [3:0] d;
      r = int'($urandom_range(0, 9));
      d = 4'($urandom);
      if (r <= 5) apply_stimulus(1'b1, 1'b0, 1'b0, d);
      else if (r == 6) apply_stimulus(1'b0, 1'b0, 1'b1, d);
      else if (r == 7) apply_stimulus(1'b0, 1'b1, 1'b0, d);
      else if (r == 8) begin
        m = 3'($urandom_range(1, 7));
        apply_stimulus(m[0], m[1], m[2], d);
      end else pulse_ready();
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/command_entry.md
# command_entry

Builds the 12-bit command word `{address[4:0], command[6:0]}` from board switches and push-buttons, one hex digit at a time. It is the input side of the command path: its `cmd_buf` drives the four-digit hex command display and the command consumer directly. Raw buttons are synchronised and debounced here. A finished command is handed off with a valid/ready handshake.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable synchronised samples required before a debounced button level changes; must be ≥ 1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `digit_in`  in  4  hex digit value from switches; sampled only on a `next` event.
- `btn_next_raw`  in  1  raw, bouncy button: store digit, advance cursor.
- `btn_enter_raw`  in  1  raw button: submit command.
- `btn_clear_raw`  in  1  raw button: clear buffer.
- `cmd_ready`  in  1  consumer accepts the command.
- `cmd_buf`  out  12  command word being edited or offered; bits [11:7] address, [6:0] command.
- `cmd_valid`  out  1  `cmd_buf` holds a submitted command.
- `cursor`  out  2  digit position the next `next` event writes.

## Operation
- Reset values: `cmd_buf`=12'h000, `cmd_valid`=0, `cursor`=0, FSM in EDIT, debouncer levels and counters 0.
- Each button passes through a 2-FF synchroniser, then a debouncer.
  - The debounced level flips only after `DEBOUNCE_CYCLES` consecutive samples that differ from the current level.
  - Any matching sample resets the counter.
  - An event is a one-cycle pulse on the rising edge of the debounced level. Release generates no event.
- Digit positions follow display order, with `digit_in` masked to each field width:
  - 0 → `cmd_buf[11]` = `digit_in[0]`.
  - 1 → `cmd_buf[10:7]` = `digit_in[3:0]`.
  - 2 → `cmd_buf[6:4]` = `digit_in[2:0]`.
  - 3 → `cmd_buf[3:0]` = `digit_in[3:0]`.
- FSM state EDIT:
  - `next` event: write the masked digit at `cursor`; `cursor` ← `cursor`+1, wrapping 3→0.
  - `clear` event: `cmd_buf` ← 0, `cursor` ← 0.
  - `enter` event: `cmd_valid` ← 1, go to PENDING. `cmd_buf` and `cursor` are unchanged.
- Simultaneous events in one cycle: only the highest-priority event acts (clear > enter > next). The others are dropped.
- FSM state PENDING:
  - `cmd_buf` is frozen and all button events are ignored and discarded (not queued).
  - When `cmd_valid && cmd_ready` on a rising edge: `cmd_valid` ← 0, `cursor` ← 0, return to EDIT. `cmd_buf` keeps its value, so the last command stays visible and editable.
- `cmd_ready` has no effect in EDIT.
- Reset asserted mid-debounce or in PENDING: immediate return to reset values. The in-flight command is lost, with no handshake completion.

## Timing
- A raw press that rises before edge 0 and then stays stable gives a synchronised level at edge 2.
  - Debounced level rises at edge 2+`DEBOUNCE_CYCLES`; the event pulse is high in the following cycle.
  - `cmd_buf`, `cursor` and `cmd_valid` update on the edge that ends the event cycle.
- Handshake: `cmd_valid` is registered. It stays high until the edge where `cmd_ready`=1 is sampled and drops after that edge. `cmd_ready` may be held high continuously, giving a 1-cycle-long `cmd_valid`.
- `cmd_buf` is fully registered with no combinational path from any input. It is stable for the whole time `cmd_valid` is high.

## Structure
- Shared package / header constants:
  - Field widths: `ADDR_W`=5, `CMD_W`=7.
  - Digit position codes 0–3.
  - FSM state encoding: EDIT, PENDING.
- One sub-module, `button_debounce`, parameter `DEBOUNCE_CYCLES`, ports `clk, rst, raw → level, press`. It contains the synchroniser, counter and edge detector, and is instantiated three times.
- The top module holds the FSM, cursor, buffer and priority logic.

## Test plan
All scenarios use bench parameter `DEBOUNCE_CYCLES`=4.
- **Digit entry:** enter digits 1, A, 5, 3 via `next` (pressing one button each, 10-cycle holds) → `cmd_buf`=12'hD53, `cursor`=0 after wrap.
- **Bounce rejection:** raw `next` toggles every 2 cycles for 20 cycles, then stays high → exactly one event; bursts shorter than 4 samples produce zero events.
- **Masking:** `digit_in`=F at position 0 and at position 2 → `cmd_buf[11]`=1, `cmd_buf[6:4]`=3'b111, other bits unchanged.
- **Handshake:**
  - `enter` with `cmd_ready`=0 → `cmd_valid` stays 1 for 50 cycles.
  - `next` and `clear` presses during that time leave `cmd_buf` unchanged.
  - `cmd_ready`=1 for one cycle → `cmd_valid`=0 on the next edge; `cursor`=0, `cmd_buf` retained.
- **Simultaneous events:**
  - `clear` and `enter` debounced on the same cycle → buffer 0, `cmd_valid` stays 0.
  - `enter` and `next` on the same cycle → `cmd_valid`=1, buffer unchanged.
- **Reset:** assert `rst` asynchronously mid-PENDING and mid-debounce → all outputs 0 immediately; a held button gives no event until it is released and pressed again.
